// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the two ROM requesters (fetch, load), the ROM and the arbiter.
// The arbiter uses the slave view; the SoC or bench drives the master view.
interface rom_port_arbiter_if #(
    parameter int AW = 12
);
    logic          if_req_i;
    logic [31:0]   if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [31:0]   if_rdata_o;
    logic          if_err_o;

    logic          ls_req_i;
    logic [31:0]   ls_addr_i;
    logic          ls_gnt_o;
    logic          ls_rvalid_o;
    logic [31:0]   ls_rdata_o;
    logic          ls_err_o;

    logic          mem_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, ls_req_i, ls_addr_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
               ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
               mem_en_o, mem_addr_o
    );

    modport master (
        output if_req_i, if_addr_i, ls_req_i, ls_addr_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
               ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
               mem_en_o, mem_addr_o
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares the single-port instruction ROM between fetch (IF) and load (LS) ports.
// IF has fixed priority; an LS wait counter forces an LS grant to avoid starvation.
module rom_port_arbiter #(
    parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
    parameter int          ROM_DEPTH = 4096,
    parameter int          AW        = 12,
    parameter int          MAX_WAIT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rom_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS
    } owner_e;

    localparam logic [31:0] ROM_BYTES = 32'(ROM_DEPTH * 4);
    localparam logic [3:0]  WAIT_MAX  = 4'(MAX_WAIT);

    logic [3:0]    wait_cnt_q, wait_cnt_d;
    owner_e        owner_q, owner_d;
    logic          resp_err_q, resp_err_d;

    logic          ls_forced;
    logic          if_gnt;
    logic          ls_gnt;
    logic [31:0]   sel_addr;
    logic [31:0]   off;
    logic          acc_err;
    logic          mem_en;
    logic [AW-1:0] mem_addr;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ls_forced = bus.ls_req_i && (wait_cnt_q == WAIT_MAX);
        if_gnt    = !rst && bus.if_req_i && !ls_forced;
        ls_gnt    = !rst && bus.ls_req_i && (!bus.if_req_i || ls_forced);

        sel_addr  = ls_gnt ? bus.ls_addr_i : bus.if_addr_i;
        // An address below ROM_BASE wraps to a large offset and is caught by the range test.
        off       = sel_addr - ROM_BASE;
        acc_err   = (sel_addr[1:0] != 2'b00) || (off >= ROM_BYTES);

        mem_en    = (if_gnt || ls_gnt) && !acc_err;
        mem_addr  = '0;
        if (mem_en) begin
            mem_addr = off[AW+1:2];
        end

        wait_cnt_d = wait_cnt_q;
        if (!bus.ls_req_i || ls_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        owner_d    = if_gnt ? OWN_IF : (ls_gnt ? OWN_LS : OWN_NONE);
        resp_err_d = (if_gnt || ls_gnt) && acc_err;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            owner_q    <= OWN_NONE;
            resp_err_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            owner_q    <= owner_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign bus.if_gnt_o    = if_gnt;
    assign bus.ls_gnt_o    = ls_gnt;
    assign bus.mem_en_o    = mem_en;
    assign bus.mem_addr_o  = mem_addr;

    // Response data is steered only to the owner and zeroed on an access error.
    assign bus.if_rvalid_o = (owner_q == OWN_IF);
    assign bus.if_err_o    = (owner_q == OWN_IF) && resp_err_q;
    assign bus.if_rdata_o  = ((owner_q == OWN_IF) && !resp_err_q) ? bus.mem_rdata_i : 32'h0;

    assign bus.ls_rvalid_o = (owner_q == OWN_LS);
    assign bus.ls_err_o    = (owner_q == OWN_LS) && resp_err_q;
    assign bus.ls_rdata_o  = ((owner_q == OWN_LS) && !resp_err_q) ? bus.mem_rdata_i : 32'h0;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: a small ROM model answers one cycle after mem_en_o,
// and each step compares DUT outputs against hand-derived values.
module tb_rom_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rom_port_arbiter_if #(.AW(12)) bus ();

    rom_port_arbiter #(
        .ROM_BASE  (32'h0000_0000),
        .ROM_DEPTH (4096),
        .AW        (12),
        .MAX_WAIT  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return {8'hC3, 12'h5A0, a};
    endfunction

    // ROM model: synchronous read, holds its output when not enabled.
    initial bus.mem_rdata_i = 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (bus.mem_en_o) bus.mem_rdata_i <= rom_word(bus.mem_addr_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0;
        bus.ls_req_i  = 1'b1;
        bus.ls_addr_i = 32'h0;
        #1;
        check("rst_if_gnt", bus.if_gnt_o, 0);
        check("rst_ls_gnt", bus.ls_gnt_o, 0);
        check("rst_mem_en", bus.mem_en_o, 0);
        check("rst_mem_addr", bus.mem_addr_o, 0);
        tick();
        check("rst_if_rvalid", bus.if_rvalid_o, 0);
        check("rst_ls_rvalid", bus.ls_rvalid_o, 0);
        check("rst_if_rdata", bus.if_rdata_o, 0);
        bus.if_req_i = 1'b0;
        bus.ls_req_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // IF-only streaming: word addresses 0,1,2 back to back.
        bus.if_req_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.if_addr_i = 32'(k * 4);
            settle();
            check($sformatf("seq_if_gnt%0d", k), bus.if_gnt_o, 1);
            check($sformatf("seq_mem_en%0d", k), bus.mem_en_o, 1);
            check($sformatf("seq_mem_addr%0d", k), bus.mem_addr_o, k);
            tick();
            check($sformatf("seq_if_rvalid%0d", k), bus.if_rvalid_o, 1);
            check($sformatf("seq_if_rdata%0d", k), bus.if_rdata_o, rom_word(12'(k)));
            check($sformatf("seq_if_err%0d", k), bus.if_err_o, 0);
        end
        bus.if_req_i = 1'b0;
        settle();
        check("idle_mem_en", bus.mem_en_o, 0);
        tick();
        check("idle_if_rvalid", bus.if_rvalid_o, 0);

        // Both requesting: IF wins 4 cycles, LS forced in cycle 5, IF again in 6.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h10;
        bus.ls_req_i  = 1'b1;
        bus.ls_addr_i = 32'h20;
        for (int k = 1; k <= 6; k++) begin
            settle();
            check($sformatf("both_if_gnt%0d", k), bus.if_gnt_o, (k != 5));
            check($sformatf("both_ls_gnt%0d", k), bus.ls_gnt_o, (k == 5));
            tick();
            check($sformatf("both_ls_rvalid%0d", k), bus.ls_rvalid_o, (k == 5));
            check($sformatf("both_if_rvalid%0d", k), bus.if_rvalid_o, (k != 5));
            if (k == 5) check("both_ls_rdata", bus.ls_rdata_o, rom_word(12'h008));
            if (k == 4) check("both_if_rdata", bus.if_rdata_o, rom_word(12'h004));
        end
        bus.if_req_i = 1'b0;
        bus.ls_req_i = 1'b0;
        tick();

        // Misaligned LS access: granted, ROM not enabled, error response.
        bus.ls_req_i  = 1'b1;
        bus.ls_addr_i = 32'h0000_0006;
        settle();
        check("mis_ls_gnt", bus.ls_gnt_o, 1);
        check("mis_mem_en", bus.mem_en_o, 0);
        check("mis_mem_addr", bus.mem_addr_o, 0);
        tick();
        bus.ls_req_i = 1'b0;
        check("mis_ls_rvalid", bus.ls_rvalid_o, 1);
        check("mis_ls_err", bus.ls_err_o, 1);
        check("mis_ls_rdata", bus.ls_rdata_o, 0);
        check("mis_if_rvalid", bus.if_rvalid_o, 0);

        // Range boundaries: first out-of-range byte, then the last word.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_4000;
        settle();
        check("oor_if_gnt", bus.if_gnt_o, 1);
        check("oor_mem_en", bus.mem_en_o, 0);
        tick();
        check("oor_if_rvalid", bus.if_rvalid_o, 1);
        check("oor_if_err", bus.if_err_o, 1);
        check("oor_if_rdata", bus.if_rdata_o, 0);
        bus.if_addr_i = 32'h0000_3FFC;
        settle();
        check("top_mem_en", bus.mem_en_o, 1);
        check("top_mem_addr", bus.mem_addr_o, 32'hFFF);
        tick();
        check("top_if_err", bus.if_err_o, 0);
        check("top_if_rdata", bus.if_rdata_o, rom_word(12'hFFF));
        bus.if_req_i = 1'b0;
        tick();

        // LS drops its request after 2 denials: the wait count restarts from 0.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0;
        bus.ls_req_i  = 1'b1;
        bus.ls_addr_i = 32'h4;
        for (int k = 1; k <= 2; k++) begin
            settle();
            check($sformatf("pulse_pre_ls_gnt%0d", k), bus.ls_gnt_o, 0);
            tick();
        end
        bus.ls_req_i = 1'b0;
        settle();
        check("pulse_gap_if_gnt", bus.if_gnt_o, 1);
        tick();
        bus.ls_req_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            settle();
            check($sformatf("pulse_ls_gnt%0d", k), bus.ls_gnt_o, (k == 5));
            check($sformatf("pulse_if_gnt%0d", k), bus.if_gnt_o, (k != 5));
            tick();
        end
        bus.ls_req_i = 1'b0;
        bus.if_req_i = 1'b0;
        tick();

        // Reset right after an IF grant discards the pending response.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h8;
        settle();
        check("mid_if_gnt", bus.if_gnt_o, 1);
        tick();
        rst = 1'b1;
        settle();
        check("mid_rst_if_gnt", bus.if_gnt_o, 0);
        check("mid_rst_mem_en", bus.mem_en_o, 0);
        tick();
        check("mid_if_rvalid", bus.if_rvalid_o, 0);
        check("mid_if_err", bus.if_err_o, 0);
        check("mid_if_rdata", bus.if_rdata_o, 0);
        check("mid_ls_rvalid", bus.ls_rvalid_o, 0);
        bus.if_req_i = 1'b0;
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-port instruction ROM between two requesters: the core's instruction-fetch port (IF) and its load port (LS), used for constant/literal loads from ROM space.
- Sits between open_risc_v and rom inside the SoC top.
- Grants one access per cycle, with IF having fixed priority and an anti-starvation counter that forces an LS grant.
- Returns read data one cycle after the grant and flags misaligned or out-of-range accesses.

Parameters:
- ROM_BASE, 32'h0000_0000, byte base address of ROM space.
- ROM_DEPTH, 4096, ROM size in 32-bit words; must be a power of 2.
- AW, 12, ROM word-address width; equals log2(ROM_DEPTH).
- MAX_WAIT, 4, consecutive denied LS cycles before LS is forced priority; range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- if_req_i  input  1  fetch request
- if_addr_i  input  32  fetch byte address
- if_gnt_o  output  1  fetch request accepted this cycle
- if_rvalid_o  output  1  fetch response valid
- if_rdata_o  output  32  fetch read data
- if_err_o  output  1  fetch access error, valid with if_rvalid_o
- ls_req_i  input  1  load request
- ls_addr_i  input  32  load byte address
- ls_gnt_o  output  1  load request accepted this cycle
- ls_rvalid_o  output  1  load response valid
- ls_rdata_o  output  32  load read data
- ls_err_o  output  1  load access error
- mem_en_o  output  1  ROM read enable
- mem_addr_o  output  AW  ROM word address
- mem_rdata_i  input  32  ROM data; valid one cycle after mem_en_o

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - All registered state cleared: wait_cnt=0, resp_owner=NONE, resp_err=0.
  - The cycle after rst is sampled high: if/ls_rvalid_o=0, err=0, rdata=0.
  - While rst is high: gnt outputs=0, mem_en_o=0, mem_addr_o=0.
- Grant is combinational, in the same cycle as req. A transfer occurs when req && gnt.
  - A requester holds req and addr stable until granted.
  - At most one gnt is asserted per cycle.
- Priority:
  - Default: IF wins when both request.
  - If ls_req_i && wait_cnt==MAX_WAIT, LS wins and IF is denied that cycle.
- wait_cnt:
  - +1 in each cycle where ls_req_i=1 and ls_gnt_o=0, saturating at MAX_WAIT.
  - Cleared on an LS grant or when ls_req_i=0.
- Address check on the granted request, with off = addr - ROM_BASE:
  - err if addr[1:0]!=0 or off >= ROM_DEPTH*4.
  - No err: mem_en_o=1, mem_addr_o=off[AW+1:2].
  - err: the request is still granted, mem_en_o=0, mem_addr_o=0.
- Response (fixed 1-cycle latency):
  - Register resp_owner (IF/LS/NONE) and resp_err at the grant.
  - Next cycle, the owner's rvalid=1, rdata=mem_rdata_i (or 0 if err), err=resp_err.
  - Non-owner outputs: rvalid=0, rdata=0, err=0.
- Throughput: back-to-back grants are allowed every cycle, so full pipelining gives one response per cycle.
- No request: mem_en_o=0, no response next cycle.
- Reset mid-operation: any response pending for the cycle after reset is discarded (rvalid stays 0).

Test Plan:
- IF only, addr 0x0,0x4,0x8 on consecutive cycles with ROM words A,B,C:
  - if_gnt_o=1 each cycle, mem_addr_o=0,1,2.
  - if_rvalid_o=1 with A,B,C in cycles 1,2,3; err=0.
- Both requesting continuously, MAX_WAIT=4:
  - IF is granted 4 cycles, then LS is granted in cycle 5 (wait_cnt==4), then IF again.
  - ls_rvalid_o=1 in cycle 6 only.
- ls_addr_i=0x0000_0006 (misaligned) alone:
  - ls_gnt_o=1, mem_en_o=0.
  - Next cycle ls_rvalid_o=1, ls_err_o=1, ls_rdata_o=0.
- if_addr_i=ROM_DEPTH*4 (0x4000) → granted; next cycle if_err_o=1. if_addr_i=0x3FFC → mem_addr_o=0xFFF, no error.
- ls_req_i pulses low after 2 denied cycles: wait_cnt returns to 0, and a further 4 denied cycles are needed before LS is forced.
- IF granted at cycle N with rst=1 in cycle N+1: if_rvalid_o=0 in cycle N+2; all outputs are at reset values.
